// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the piso_tx serial transmitter.
// PISO_TX_PARITY_EN adds the PARITY state to the state enum.
package piso_tx_pkg;

    localparam int   WIDTH_DEFAULT = 8;
    localparam logic IDLE_LEVEL    = 1'b1;

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for piso_tx; saturates at WIDTH-1 and flags the last bit.
module piso_bit_cnt
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic last
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // clear (active-high here) wins over incr; incr stops at the terminal count
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (incr && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, registered output idling high.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enable,
    input  logic             clear,
    output logic             out_1,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             out_n;
    logic             done_n;
    logic             cnt_clear;
    logic             cnt_incr;
    logic             cnt_last;

`ifdef PISO_TX_PARITY_EN
    logic par_q;

    // parity of the whole word is taken at capture, before any rotation
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (load_valid && load_ready) begin
            par_q <= ^data_in;
        end
    end
`endif

    assign load_ready = (state == IDLE) && clear;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        out_n     = out_1;
        done_n    = 1'b0;
        cnt_clear = 1'b0;
        cnt_incr  = 1'b0;
        if (!clear) begin
            state_n   = IDLE;
            out_n     = IDLE_LEVEL;
            cnt_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state_n   = SHIFT;
                        shreg_n   = data_in;
                        out_n     = data_in[WIDTH-1];
                        cnt_clear = 1'b1;
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        if (!cnt_last) begin
                            // rotate so the next bit lands in the MSB
                            shreg_n  = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
                            out_n    = shreg[WIDTH-2];
                            cnt_incr = 1'b1;
                        end else begin
`ifdef PISO_TX_PARITY_EN
                            state_n   = PARITY;
                            out_n     = par_q;
`else
                            state_n   = IDLE;
                            out_n     = IDLE_LEVEL;
                            done_n    = 1'b1;
                            cnt_clear = 1'b1;
`endif
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    if (enable) begin
                        state_n   = IDLE;
                        out_n     = IDLE_LEVEL;
                        done_n    = 1'b1;
                        cnt_clear = 1'b1;
                    end
                end
`endif
                default: begin
                    state_n   = IDLE;
                    out_n     = IDLE_LEVEL;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            out_1 <= IDLE_LEVEL;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            out_1 <= out_n;
            done  <= done_n;
        end
    end

    piso_bit_cnt #(
        .WIDTH(WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .incr (cnt_incr),
        .last (cnt_last)
    );

endmodule
